result_reader: RTL and testbench

- Read-side counterpart to the result memory writer path: sequentially fetches a block of result words from a MEM_DEPTH x MEM_WIDTH result memory through an address/request port.
- Streams the fetched words out on a valid/ready interface to a downstream consumer (checker, DPI bridge, UART dumper).
- Contains a 2-entry output FIFO so that memory read latency and downstream backpressure never drop or duplicate a word.

---
 rtl/result_reader.sv | 171 +++++++++++++++++
 tb/tb_result_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_reader.sv
// rtl/result_reader.sv - burst reader from result memory to a valid/ready stream
module result_reader #(
  parameter int MEM_DEPTH = 8,
  parameter int MEM_WIDTH = 32,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AW-1:0]        start_addr_i,
  input  logic [CW-1:0]        count_i,
  output logic                 mem_req_o,
  output logic [AW-1:0]        mem_addr_o,
  input  logic [MEM_WIDTH-1:0] mem_data_i,
  output logic [MEM_WIDTH-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [AW-1:0]        r_addr;
  logic [CW-1:0]        r_remaining;
  logic                 r_inflight;
  logic                 r_inflight_last;
  // Two-entry FIFO kept as a shift pair: entry 0 is always the head.
  logic [MEM_WIDTH-1:0] r_d0;
  logic [MEM_WIDTH-1:0] r_d1;
  logic                 r_l0;
  logic                 r_l1;
  logic [1:0]           r_cnt;

  logic [CW-1:0]        w_count_clamped;
  logic                 w_valid;
  logic                 w_pop;
  logic                 w_push;
  logic [2:0]           w_occ;
  logic                 w_room;
  logic                 w_req;

  assign w_count_clamped = (count_i > CW'(MEM_DEPTH)) ? CW'(MEM_DEPTH) : count_i;
  assign w_valid = (r_cnt != 2'd0);
  assign w_pop   = w_valid & ready_i;
  // Data for a request always lands the cycle after it was issued.
  assign w_push  = r_inflight;
  // Occupancy counts the word still in flight so a request is never issued
  // without a guaranteed FIFO slot; a same-cycle pop frees one slot.
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight};
  assign w_room  = (w_occ < (3'd2 + {2'b00, w_pop}));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and read-issue decision
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_next = (w_count_clamped == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if ((r_remaining != '0) && w_room) begin
          w_req = 1'b1;
          if (r_remaining == CW'(1)) begin
            w_state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_pop && r_l0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Address/remaining counters and in-flight tracking (reset drops the in-flight word)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start_i) begin
        r_addr      <= start_addr_i;
        r_remaining <= w_count_clamped;
      end else if (w_req) begin
        r_addr      <= r_addr + AW'(1);
        r_remaining <= r_remaining - CW'(1);
      end
      r_inflight      <= w_req;
      r_inflight_last <= w_req && (r_remaining == CW'(1));
    end
  end

  // Output FIFO: capture landed data, shift on pop, both when simultaneous
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_l0  <= 1'b0;
      r_l1  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_d0 <= mem_data_i;
            r_l0 <= r_inflight_last;
          end else begin
            r_d1 <= mem_data_i;
            r_l1 <= r_inflight_last;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_l0  <= r_l1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_d0 <= mem_data_i;
            r_l0 <= r_inflight_last;
          end else begin
            r_d0 <= r_d1;
            r_l0 <= r_l1;
            r_d1 <= mem_data_i;
            r_l1 <= r_inflight_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && !w_pop && (r_cnt == 2'd2)));

  assign mem_req_o  = w_req;
  assign mem_addr_o = r_addr;
  assign data_o     = r_d0;
  assign valid_o    = w_valid;
  assign last_o     = r_l0 & w_valid;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);

endmodule

// File: tb/tb_result_reader.sv
// tb/tb_result_reader.sv - scoreboard bench for result_reader
module tb_result_reader;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  start_addr_i;
  logic [3:0]  count_i;
  logic        mem_req_o;
  logic [2:0]  mem_addr_o;
  logic [31:0] mem_data_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;
  logic        busy_o;
  logic        done_o;

  logic [31:0] mem [8];
  logic [32:0] sb_q [$];
  int          total = 0;
  int          bad   = 0;

  result_reader #(.MEM_DEPTH(8), .MEM_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .count_i      (count_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_i   (mem_data_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle read latency
  always @(posedge clk) begin
    if (mem_req_o) mem_data_i <= mem[mem_addr_o];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each transfer and checks stall stability
  initial begin
    logic        stall_prev;
    logic [31:0] held_d;
    logic        held_l;
    logic [32:0] e;
    stall_prev = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_i && valid_o) begin
        if (stall_prev) begin
          check("stall_data", data_o, held_d);
          check("stall_last", last_o, held_l);
        end
        if (ready_i) begin
          if (sb_q.size() == 0) begin
            check("unexpected_word", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("data", data_o, e[31:0]);
            check("last", last_o, e[32]);
          end
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          held_d = data_o;
          held_l = last_o;
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  function automatic int clamp(input logic [3:0] c);
    return (c > 4'd8) ? 8 : int'(c);
  endfunction

  task automatic start_burst(input logic [2:0] a, input logic [3:0] c);
    int n;
    logic [2:0] ix;
    n = clamp(c);
    for (int i = 0; i < n; i++) begin
      ix = a + 3'(i);
      sb_q.push_back({(i == n - 1), mem[ix]});
    end
    start_i = 1'b1;
    start_addr_i = a;
    count_i = c;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input bit rnd, input bit poke, output int reqs);
    bit seen;
    reqs = 0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (mem_req_o) reqs++;
      if (done_o) begin
        seen = 1'b1;
      end else if (poke && busy_o && ($urandom_range(0, 3) == 0)) begin
        start_i = 1'b1;
        start_addr_i = 3'($urandom_range(0, 7));
        count_i = 4'($urandom_range(0, 15));
      end
      @(posedge clk);
      #1;
      start_i = 1'b0;
      if (rnd) ready_i = 1'($urandom_range(0, 1));
    end
    check("done_seen", seen, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, mem_req_o, 0);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_last"}, last_o, 0);
    check({tag, "_data"}, data_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    int reqs;
    int idx;
    logic [2:0] wrap_exp [4];
    logic [2:0] ra;
    logic [3:0] rc;
    wrap_exp[0] = 3'd6;
    wrap_exp[1] = 3'd7;
    wrap_exp[2] = 3'd0;
    wrap_exp[3] = 3'd1;
    for (int i = 0; i < 8; i++) mem[i] = 32'(i * 3);
    rst_i = 1'b1;
    start_i = 1'b0;
    start_addr_i = '0;
    count_i = '0;
    ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Full-rate burst: words in T+3..T+10, done at T+11
    ready_i = 1'b1;
    start_burst(3'd0, 4'd8);
    reqs = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) check("fr_first_req", mem_req_o, 1);
      check("fr_valid", valid_o, (k >= 3 && k <= 10));
      check("fr_done", done_o, (k == 11));
      if (mem_req_o) reqs++;
      @(posedge clk);
      #1;
    end
    check("fr_reqs", reqs, 8);
    check("fr_sb_empty", sb_q.size(), 0);

    // Reset in the cycle of the third transfer
    start_burst(3'd0, 4'd8);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_all_zero("midrst");
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("midrst_no_valid", valid_o, 0);
      check("midrst_no_req", mem_req_o, 0);
    end
    @(posedge clk);
    #1;
    start_burst(3'd3, 4'd3);
    run_until_done(1'b0, 1'b0, reqs);
    check("midrst_restart_reqs", reqs, 3);
    check("midrst_sb_empty", sb_q.size(), 0);

    // Wrap-around: addresses 6,7,0,1
    start_burst(3'd6, 4'd4);
    idx = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_req_o) begin
        if (idx < 4) check("wrap_addr", mem_addr_o, wrap_exp[idx]);
        else check("wrap_extra_req", 1, 0);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    check("wrap_req_count", idx, 4);
    check("wrap_sb_empty", sb_q.size(), 0);

    // Backpressure: consumer stalled through T+9
    ready_i = 1'b0;
    start_burst(3'd0, 4'd5);
    reqs = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (mem_req_o) reqs++;
      check("bp_valid", valid_o, (k >= 3));
      if (k == 9) check("bp_req_stopped", mem_req_o, 0);
      @(posedge clk);
      #1;
    end
    check("bp_buffered_reqs", reqs, 2);
    ready_i = 1'b1;
    run_until_done(1'b0, 1'b0, reqs);
    check("bp_resumed_reqs", reqs, 3);
    check("bp_sb_empty", sb_q.size(), 0);

    // Zero count: done the cycle after start, no requests
    start_burst(3'd0, 4'd0);
    @(negedge clk);
    check("zero_done", done_o, 1);
    check("zero_req", mem_req_o, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("zero_done_pulse", done_o, 0);
    check("zero_idle", busy_o, 0);
    @(posedge clk);
    #1;

    // Oversize count clamps to 8
    start_burst(3'd2, 4'd15);
    run_until_done(1'b0, 1'b0, reqs);
    check("oversize_reqs", reqs, 8);
    check("oversize_sb_empty", sb_q.size(), 0);

    // Random bursts with random backpressure and ignored start pulses
    for (int b = 0; b < 100; b++) begin
      if (b % 10 == 0) begin
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
      end
      ra = 3'($urandom_range(0, 7));
      rc = 4'($urandom_range(0, 15));
      start_burst(ra, rc);
      run_until_done(1'b1, 1'b1, reqs);
      check("rnd_reqs", reqs, clamp(rc));
    end
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rnd_sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
